// File: rtl/delay_analog.sv
// Programmable-delay history buffer for fixed-point analog samples: stores one sample per cke step
// and registers the sample from `delay` steps earlier. Optional macro: DELAY_ANALOG_HOLD_OLDEST_EN.
module delay_analog #(
    parameter int  depth   = 4,
    parameter real init    = 0.0,
    parameter int  in_w    = 16,
    parameter int  in_exp  = -8,
    parameter int  out_w   = 18,
    parameter int  out_exp = -10,
    localparam int DW      = $clog2(depth + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cke,
    input  logic signed [in_w-1:0]  in,
    input  logic        [DW-1:0]    delay,
    output logic signed [out_w-1:0] out,
    output logic                    valid
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int AW = DW + 1;
    localparam int SH = in_exp - out_exp;
    localparam int XW = in_w + ((SH > 0) ? SH : 0) + out_w;
    localparam logic [DW-1:0] DEPTH_D = DW'(depth);
    localparam logic signed [out_w-1:0] INIT_FX = out_w'($rtoi(init * (2.0 ** (-out_exp))));

    logic signed [out_w-1:0] mem [depth];
    logic [PW-1:0]           wr_ptr;
    logic [DW-1:0]           count;
    logic [DW-1:0]           d;
    logic signed [XW-1:0]    in_ext;
    logic signed [XW-1:0]    in_shift;
    logic signed [out_w-1:0] in_aligned;
    logic signed [out_w-1:0] nxt_out;
    logic                    nxt_valid;

    // Re-scale the input LSB weight (2^in_exp) to the storage/output weight (2^out_exp).
    assign in_ext = XW'(in);
    generate
        if (SH >= 0) begin : g_left
            assign in_shift = in_ext <<< SH;
        end else begin : g_right
            assign in_shift = in_ext >>> (-SH);
        end
    endgenerate
    assign in_aligned = in_shift[out_w-1:0];

    // Index of the entry written `lag` steps ago, wrapping explicitly for non-power-of-2 depth.
    function automatic logic [PW-1:0] lag_idx(input logic [PW-1:0] ptr, input logic [DW-1:0] lag);
        logic [AW-1:0] p;
        logic [AW-1:0] l;
        p = AW'(ptr);
        l = AW'(lag);
        if (p >= l) return PW'(p - l);
        else        return PW'(p + AW'(depth) - l);
    endfunction

    always_comb begin
        d         = (delay > DEPTH_D) ? DEPTH_D : delay;
        nxt_out   = INIT_FX;
        nxt_valid = 1'b0;
        if (d == '0) begin
            nxt_out   = in_aligned;
            nxt_valid = 1'b1;
        end else if (d <= count) begin
            nxt_out   = mem[lag_idx(wr_ptr, d)];
            nxt_valid = 1'b1;
        end
`ifdef DELAY_ANALOG_HOLD_OLDEST_EN
        else if (count != '0) begin
            nxt_out = mem[lag_idx(wr_ptr, count)];
        end
`else
`endif
    end

    // Memory has no reset so it can map onto RAM; count masks stale entries instead.
    always_ff @(posedge clk) begin
        if (cke && !rst) mem[wr_ptr] <= in_aligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out    <= INIT_FX;
            valid  <= 1'b0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cke) begin
            out    <= nxt_out;
            valid  <= nxt_valid;
            wr_ptr <= (wr_ptr == PW'(depth - 1)) ? '0 : wr_ptr + 1'b1;
            count  <= (count == DEPTH_D) ? count : count + 1'b1;
        end
    end

endmodule
